obstacle_spawner: RTL

Producer side of the player/obstacle collision interface. Holds a small pool of obstacle slots, spawns obstacles at pseudo-random lanes, and scrolls them toward the player on each frame tick. Retires obstacles that pass the player and counts them as dodges. Presents the nearest live obstacle (lane, vertical offset, ignore flag) to the collision checker, and consumes its has_collision result to end the run.

---
 rtl/obstacle_spawner.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: obstacle pool, frame-driven scroller and nearest-obstacle presenter
// for the player/obstacle collision checker. Ends the run on a qualified collision.
// Optional speed ramp: define OBSTACLE_SPEEDUP_EN to raise the scroll speed by one
// every SPEEDUP_DODGES dodges, capped at MAX_SPEED. Without it the speed is BASE_SPEED.
module obstacle_spawner #(
  parameter int unsigned VWIDTH         = 12,
  parameter int unsigned LWIDTH         = 2,
  parameter int unsigned NUM_LANES      = 3,
  parameter int unsigned SLOTS          = 4,
  parameter int          SPAWN_V        = -16,
  parameter int          DESPAWN_V      = 480,
  parameter int unsigned SPAWN_GAP      = 30,
  parameter int unsigned BASE_SPEED     = 2,
  parameter int unsigned MAX_SPEED      = 8,
  parameter int unsigned SPEEDUP_DODGES = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     frame_tick_i,
  input  logic                     has_collision_i,
  output logic                     obst_valid_o,
  output logic [LWIDTH-1:0]        obst_lane_o,
  output logic signed [VWIDTH-1:0] obst_voffset_o,
  output logic                     ignore_obstacle_o,
  output logic [COUNT_WIDTH-1:0]   dodged_count_o,
  output logic                     game_over_o,
  output logic [1:0]               state_o
);

  localparam int unsigned VW1  = VWIDTH + 1;
  localparam int unsigned LW1  = LWIDTH + 1;
  localparam int unsigned CntW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned SpdW = $clog2(MAX_SPEED + 1);
  localparam int unsigned RetW = $clog2(SLOTS + 1);
  localparam int unsigned SumW = COUNT_WIDTH + 1;

  localparam logic [CntW-1:0]          GapLast   = CntW'(SPAWN_GAP - 1);
  localparam logic signed [VWIDTH:0]   DespawnV  = VW1'(DESPAWN_V);
  localparam logic signed [VWIDTH-1:0] SpawnV    = VWIDTH'(SPAWN_V);
  localparam logic [LWIDTH:0]          NumLanes  = LW1'(NUM_LANES);
  localparam logic [SpdW-1:0]          BaseSpeed = SpdW'(BASE_SPEED);

  // Reject parameter sets the datapath cannot represent.
  if (LFSR_SEED == 16'h0 || SPEEDUP_DODGES == 0 || MAX_SPEED < BASE_SPEED ||
      NUM_LANES == 0 || NUM_LANES > (1 << LWIDTH)) begin : gen_bad_params
    $error("obstacle_spawner: illegal parameter set");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  // Architectural state
  state_e                   state_q;
  logic [15:0]              lfsr_q;
  logic [SLOTS-1:0]         valid_q;
  logic [LWIDTH-1:0]        lane_q [SLOTS];
  logic signed [VWIDTH-1:0] voff_q [SLOTS];
  logic [CntW-1:0]          spawn_cnt_q;
  logic [COUNT_WIDTH-1:0]   dodged_q;
  logic                     pres_valid_q;
  logic [LWIDTH-1:0]        pres_lane_q;
  logic signed [VWIDTH-1:0] pres_voff_q;

  // Frame-tick results, committed only when a tick is applied in RUN
  logic [SLOTS-1:0]         valid_d;
  logic [LWIDTH-1:0]        lane_d [SLOTS];
  logic signed [VWIDTH-1:0] voff_d [SLOTS];
  logic signed [VWIDTH:0]   v_next [SLOTS];
  logic signed [VWIDTH:0]   speed_ext;
  logic [SpdW-1:0]          speed;
  logic [RetW-1:0]          ret_cnt;
  logic                     spawn_due;
  logic                     spawn_placed;
  logic [CntW-1:0]          spawn_cnt_d;
  logic [SumW-1:0]          dodged_sum;
  logic [COUNT_WIDTH-1:0]   dodged_d;
  logic [LWIDTH:0]          lane_raw;
  logic [LWIDTH-1:0]        spawn_lane;

  // Front-slot selection
  logic                     front_valid;
  logic [LWIDTH-1:0]        front_lane;
  logic signed [VWIDTH-1:0] front_voff;

  // Control
  logic                     collide;
  logic                     run_entry;
  logic                     tick_apply;

  // Collision only counts against a presented obstacle while running.
  assign collide    = has_collision_i && (state_q == StRun) && pres_valid_q;
  assign run_entry  = (state_q != StRun) && start_i;
  assign tick_apply = (state_q == StRun) && !collide && frame_tick_i;

  // Fold out-of-range LFSR lane values back into the legal lane range.
  assign lane_raw   = {1'b0, lfsr_q[LWIDTH-1:0]};
  assign spawn_lane = (lane_raw >= NumLanes) ? LWIDTH'(lane_raw - NumLanes)
                                             : lfsr_q[LWIDTH-1:0];

  assign speed_ext  = $signed(VW1'(speed));

  // Scroll, retire and spawn for one frame tick.
  always_comb begin
    valid_d      = valid_q;
    ret_cnt      = '0;
    spawn_placed = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      lane_d[i] = lane_q[i];
      // One extra bit so a slot near the bottom cannot wrap negative.
      v_next[i] = {voff_q[i][VWIDTH-1], voff_q[i]} + speed_ext;
      voff_d[i] = valid_q[i] ? v_next[i][VWIDTH-1:0] : voff_q[i];
      if (valid_q[i] && (v_next[i] > DespawnV)) begin
        valid_d[i] = 1'b0;
        ret_cnt    = ret_cnt + RetW'(1);
      end
    end

    spawn_due   = (spawn_cnt_q == GapLast);
    spawn_cnt_d = spawn_due ? '0 : spawn_cnt_q + CntW'(1);

    // Slots freed by this tick's retirements are eligible for the spawn.
    if (spawn_due) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (!spawn_placed && !valid_d[i]) begin
          spawn_placed = 1'b1;
          valid_d[i]   = 1'b1;
          voff_d[i]    = SpawnV;
          lane_d[i]    = spawn_lane;
        end
      end
    end

    dodged_sum = {1'b0, dodged_q} + SumW'(ret_cnt);
    dodged_d   = dodged_sum[COUNT_WIDTH] ? '1 : dodged_sum[COUNT_WIDTH-1:0];
  end

  // Front slot: greatest voffset, ties resolved toward the lowest index.
  always_comb begin
    front_valid = 1'b0;
    front_lane  = '0;
    front_voff  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (valid_q[i] && (!front_valid || (voff_q[i] > front_voff))) begin
        front_valid = 1'b1;
        front_lane  = lane_q[i];
        front_voff  = voff_q[i];
      end
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  localparam int unsigned     StepW    = $clog2(SPEEDUP_DODGES + SLOTS + 1);
  localparam logic [StepW-1:0] StepLen  = StepW'(SPEEDUP_DODGES);
  localparam logic [SpdW-1:0]  MaxSpeed = SpdW'(MAX_SPEED);

  logic [SpdW-1:0]  speed_q;
  logic [SpdW-1:0]  speed_d;
  logic [StepW-1:0] step_q;
  logic [StepW-1:0] step_d;
  logic [StepW-1:0] step_sum;

  // step_q tracks dodges since the last multiple of SPEEDUP_DODGES.
  always_comb begin
    step_sum = step_q + StepW'(ret_cnt);
    step_d   = step_sum;
    speed_d  = speed_q;
    if (step_sum >= StepLen) begin
      step_d = step_sum - StepLen;
      if (speed_q < MaxSpeed) begin
        speed_d = speed_q + SpdW'(1);
      end
    end
  end

  // Speed register; a new speed takes effect from the following tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= BaseSpeed;
      step_q  <= '0;
    end else if (run_entry) begin
      speed_q <= BaseSpeed;
      step_q  <= '0;
    end else if (tick_apply) begin
      speed_q <= speed_d;
      step_q  <= step_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = BaseSpeed;
`endif

  // Free-running lane source, x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Run FSM with slot pool, counters and registered presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      spawn_cnt_q  <= '0;
      dodged_q     <= '0;
      pres_valid_q <= 1'b0;
      pres_lane_q  <= '0;
      pres_voff_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        lane_q[i] <= '0;
        voff_q[i] <= '0;
      end
    end else begin
      // Presentation trails the slot contents by one cycle.
      pres_valid_q <= front_valid;
      pres_lane_q  <= front_lane;
      pres_voff_q  <= front_voff;
      unique case (state_q)
        StIdle, StOver: begin
          if (start_i) begin
            state_q      <= StRun;
            valid_q      <= '0;
            spawn_cnt_q  <= '0;
            dodged_q     <= '0;
            // Drop any stale obstacle so the checker never sees the old run.
            pres_valid_q <= 1'b0;
            pres_lane_q  <= '0;
            pres_voff_q  <= '0;
          end
        end
        StRun: begin
          if (collide) begin
            state_q <= StOver;
          end else if (frame_tick_i) begin
            valid_q     <= valid_d;
            spawn_cnt_q <= spawn_cnt_d;
            dodged_q    <= dodged_d;
            for (int i = 0; i < SLOTS; i++) begin
              lane_q[i] <= lane_d[i];
              voff_q[i] <= voff_d[i];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign obst_valid_o      = pres_valid_q;
  assign obst_lane_o       = pres_lane_q;
  assign obst_voffset_o    = pres_voff_q;
  assign ignore_obstacle_o = !pres_valid_q || (state_q != StRun);
  assign dodged_count_o    = dodged_q;
  assign game_over_o       = (state_q == StOver);
  assign state_o           = state_q;

endmodule
